// File: rtl/int_regfile_sb.sv
// int_regfile_sb: integer register file with a per-register scoreboard.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   rd_we/rd_idx/rd_data: write port; index 0 is hardwired to zero
//   rs_re/rs_idx        : NRD read requests, port i at rs_idx[i*AW +: AW]
//   rs_data/rs_valid    : registered read results, valid one cycle after request
//   sb_set/sb_idx       : mark a register pending (long-latency op in flight)
//   hazard              : combinational, read targets a pending, unforwarded reg
//   pending             : registered scoreboard vector (bit 0 always 0)

// One read port: operand select with optional write forwarding, hazard
// detect and the output register.
module int_regfile_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_re,
  input  logic [AW-1:0]   i_idx,
  input  logic [XLEN-1:0] i_reg_val,
  input  logic            i_pend,
  input  logic            i_we,       // already qualified with wr_idx != 0
  input  logic [AW-1:0]   i_wr_idx,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_data,
  output logic            o_valid,
  output logic            o_hazard
);
  logic            w_fwd;
  logic [XLEN-1:0] w_val;
  logic [XLEN-1:0] r_data;
  logic            r_valid;

  // i_we is never set for index 0, so forwarding cannot leak into x0.
  assign w_fwd = (BYPASS != 0) && i_we && (i_wr_idx == i_idx);

  always_comb begin
    w_val = i_reg_val;
    if (i_idx == '0) w_val = '0;
    else if (w_fwd)  w_val = i_wr_data;
  end

  // A write landing this cycle clears the hazard only when it is forwarded.
  assign o_hazard = i_re & i_pend & ~w_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_re;
      if (i_re) r_data <= w_val;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

module int_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_we,
  input  logic [AW-1:0]     rd_idx,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [NRD-1:0]    rs_re,
  input  logic [NRD*AW-1:0] rs_idx,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_valid,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_idx,
  output logic [NRD-1:0]    hazard,
  output logic [NREGS-1:0]  pending
);
  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0]           r_pend;
  logic [NREGS-1:0]           w_pend_nxt;
  logic                       w_we;

  assign w_we = rd_we && (rd_idx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_regs <= '0;
    else if (w_we) r_regs[rd_idx] <= rd_data;
  end

  // Clear first, then set, so a same-cycle set on the written index wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_we) w_pend_nxt[rd_idx] = 1'b0;
    if (sb_set && (sb_idx != '0)) w_pend_nxt[sb_idx] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_nxt;
  end

  assign pending = r_pend;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_idx;
    assign w_idx = rs_idx[g*AW +: AW];

    int_regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .clk       (clk),
      .rst       (rst),
      .i_re      (rs_re[g]),
      .i_idx     (w_idx),
      .i_reg_val (r_regs[w_idx]),
      .i_pend    (r_pend[w_idx]),
      .i_we      (w_we),
      .i_wr_idx  (rd_idx),
      .i_wr_data (rd_data),
      .o_data    (rs_data[g*XLEN +: XLEN]),
      .o_valid   (rs_valid[g]),
      .o_hazard  (hazard[g])
    );
  end
endmodule

// File: tb/tb_int_regfile_sb.sv
module tb_int_regfile_sb;
  localparam int AW = 5;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_we;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic [1:0]  rs_re;
  logic [9:0]  rs_idx;
  logic        sb_set;
  logic [4:0]  sb_idx;

  logic [63:0] data1, data0;
  logic [1:0]  valid1, valid0, haz1, haz0;
  logic [31:0] pend1, pend0;

  int passes = 0;
  int total  = 0;

  // Reference model state
  logic [31:0] m_regs [NR];
  logic [31:0] m_pend;
  logic [31:0] m_d1 [2];
  logic [31:0] m_d0 [2];
  logic [1:0]  m_v;

  always #5 clk = ~clk;

  int_regfile_sb #(.BYPASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .rd_we(rd_we), .rd_idx(rd_idx), .rd_data(rd_data),
    .rs_re(rs_re), .rs_idx(rs_idx), .rs_data(data1), .rs_valid(valid1),
    .sb_set(sb_set), .sb_idx(sb_idx), .hazard(haz1), .pending(pend1));

  int_regfile_sb #(.BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_we(rd_we), .rd_idx(rd_idx), .rd_data(rd_data),
    .rs_re(rs_re), .rs_idx(rs_idx), .rs_data(data0), .rs_valid(valid0),
    .sb_set(sb_set), .sb_idx(sb_idx), .hazard(haz0), .pending(pend0));

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_pend = '0;
    m_d1[0] = '0; m_d1[1] = '0; m_d0[0] = '0; m_d0[1] = '0;
    m_v = '0;
  endtask

  // Apply the architectural rules for one clock edge using current inputs.
  task automatic model_edge();
    int k;
    logic [31:0] old;
    if (rst) return;
    for (int i = 0; i < 2; i++) begin
      k = int'(rs_idx[i*AW +: AW]);
      m_v[i] = rs_re[i];
      if (rs_re[i]) begin
        old = (k == 0) ? 32'd0 : m_regs[k];
        m_d0[i] = old;
        m_d1[i] = (k != 0 && rd_we && int'(rd_idx) == k) ? rd_data : old;
      end
    end
    if (rd_we && rd_idx != 0) begin
      m_pend[rd_idx] = 1'b0;
      m_regs[rd_idx] = rd_data;
    end
    if (sb_set && sb_idx != 0) m_pend[sb_idx] = 1'b1;
  endtask

  function automatic logic [1:0] exp_haz(input bit bp);
    logic [1:0] h;
    int k;
    for (int i = 0; i < 2; i++) begin
      k = int'(rs_idx[i*AW +: AW]);
      h[i] = rs_re[i] && m_pend[k] && !(bp && rd_we && int'(rd_idx) == k && k != 0);
    end
    return h;
  endfunction

  task automatic drive(input logic we, input logic [4:0] widx, input logic [31:0] wdata,
                       input logic [1:0] re, input logic [4:0] i0, input logic [4:0] i1,
                       input logic ss, input logic [4:0] sidx);
    rd_we = we; rd_idx = widx; rd_data = wdata;
    rs_re = re; rs_idx = {i1, i0};
    sb_set = ss; sb_idx = sidx;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  // Model follows the edge, then outputs are sampled 1 time unit after it.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    total++;
    if ({data1, data0, valid1, valid0, pend1, pend0} !== '0)
      $display("FAIL reset_outputs: got d1=%h d0=%h v=%b/%b p=%h/%h want all 0",
               data1, data0, valid1, valid0, pend1, pend0);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    // x7 has never been written, so the pre-write value is 0.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
    tick();
    total++;
    if (data1[31:0] !== 32'hA5A5A5A5 || valid1[0] !== 1'b1)
      $display("FAIL bypass_on: got %h v=%b want a5a5a5a5 v=1", data1[31:0], valid1[0]);
    else passes++;
    total++;
    if (data0[31:0] !== 32'h0 || valid0[0] !== 1'b1)
      $display("FAIL bypass_off: got %h v=%b want 0 v=1", data0[31:0], valid0[0]);
    else passes++;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0);
    tick();
    total++;
    if (data1[31:0] !== 32'hDEADBEEF || valid1 !== 2'b01)
      $display("FAIL write_read: got %h v=%b want deadbeef v=01", data1[31:0], valid1);
    else passes++;
    // Idle cycle: data holds, valid drops.
    @(negedge clk);
    idle();
    tick();
    total++;
    if (data1[31:0] !== 32'hDEADBEEF || valid1 !== 2'b00)
      $display("FAIL read_hold: got %h v=%b want deadbeef v=00", data1[31:0], valid1);
    else passes++;
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive(1'b1, 5'd0, 32'h12345678, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0);
    #1;
    total++;
    if (haz1 !== 2'b00 || haz0 !== 2'b00)
      $display("FAIL x0_hazard: got %b/%b want 00/00", haz1, haz0);
    else passes++;
    tick();
    total++;
    if (data1 !== 64'd0 || data0 !== 64'd0 || valid1 !== 2'b11)
      $display("FAIL x0_read: got %h/%h v=%b want 0/0 v=11", data1, data0, valid1);
    else passes++;
    total++;
    if (pend1[0] !== 1'b0 || pend0[0] !== 1'b0)
      $display("FAIL x0_pending: got %b/%b want 0/0", pend1[0], pend0[0]);
    else passes++;
  endtask

  task automatic test_scoreboard();
    // Same-cycle set does not raise hazard yet.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd3, 5'd0, 1'b1, 5'd3);
    #1;
    total++;
    if (haz1[0] !== 1'b0)
      $display("FAIL sb_same_cycle: got hazard=%b want 0", haz1[0]);
    else passes++;
    tick();
    total++;
    if (pend1[3] !== 1'b1 || valid1[0] !== 1'b1)
      $display("FAIL sb_set: got pending3=%b valid=%b want 1 1", pend1[3], valid1[0]);
    else passes++;
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0);
    #1;
    total++;
    if (haz1 !== 2'b11 || haz0 !== 2'b11)
      $display("FAIL sb_hazard: got %b/%b want 11/11", haz1, haz0);
    else passes++;
    tick();
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h1, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0);
    #1;
    total++;
    if (haz1[0] !== 1'b0 || haz0[0] !== 1'b1)
      $display("FAIL sb_fwd_hazard: got %b/%b want 0/1", haz1[0], haz0[0]);
    else passes++;
    tick();
    total++;
    if (pend1[3] !== 1'b0 || data1[31:0] !== 32'h1 || data0[31:0] !== 32'h0)
      $display("FAIL sb_clear: got p3=%b d1=%h d0=%h want 0 1 0", pend1[3], data1[31:0], data0[31:0]);
    else passes++;
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9);
    tick();
    total++;
    if (pend1[9] !== 1'b1 || pend0[9] !== 1'b1)
      $display("FAIL set_wins: got %b/%b want 1/1", pend1[9], pend0[9]);
    else passes++;
  endtask

  task automatic test_random();
    logic [4:0] wi, i0, i1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wi = 5'($urandom_range(0, 31));
      // Bias read indices toward the write index to exercise forwarding.
      i0 = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      i1 = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wi, $urandom, 2'($urandom_range(0, 3)),
            i0, i1, 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
      #1;
      total++;
      if (haz1 !== exp_haz(1'b1) || haz0 !== exp_haz(1'b0))
        $display("FAIL rnd_hazard[%0d]: got %b/%b want %b/%b", n, haz1, haz0, exp_haz(1'b1), exp_haz(1'b0));
      else passes++;
      tick();
      total++;
      if (data1 !== {m_d1[1], m_d1[0]} || data0 !== {m_d0[1], m_d0[0]} ||
          valid1 !== m_v || valid0 !== m_v || pend1 !== m_pend || pend0 !== m_pend)
        $display("FAIL rnd_state[%0d]: got d1=%h d0=%h v=%b/%b p=%h/%h want d1=%h d0=%h v=%b p=%h",
                 n, data1, data0, valid1, valid0, pend1, pend0,
                 {m_d1[1], m_d1[0]}, {m_d0[1], m_d0[0]}, m_v, m_pend);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k < NR; k++) begin
      @(negedge clk);
      drive(1'b1, 5'(k), 32'h1000 + 32'(k), 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd4, 5'd5, 1'b1, 5'd4);
    tick();
    total++;
    if (pend1[4] !== 1'b1 || valid1 !== 2'b11 || data1[31:0] !== 32'h1004)
      $display("FAIL preload: got p4=%b v=%b d=%h want 1 11 1004", pend1[4], valid1, data1[31:0]);
    else passes++;
    // Assert reset between edges with a read in flight.
    drive(1'b1, 5'd6, 32'hFFFF, 2'b11, 5'd4, 5'd4, 1'b1, 5'd4);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({data1, data0, valid1, valid0, pend1, pend0, haz1, haz0} !== '0)
      $display("FAIL reset_mid: got d1=%h v=%b p=%h h=%b want all 0", data1, valid1, pend1, haz1);
    else passes++;
    tick();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd4, 5'd6, 1'b0, 5'd0);
    #1;
    total++;
    if (haz1 !== 2'b00)
      $display("FAIL reset_hazard: got %b want 00", haz1);
    else passes++;
    tick();
    total++;
    if (data1 !== 64'd0 || valid1 !== 2'b11 || pend1 !== 32'd0)
      $display("FAIL reset_read: got d=%h v=%b p=%h want 0 11 0", data1, valid1, pend1);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_set_wins();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
